// File: rtl/mult_err_analyzer.sv
// mult_err_analyzer: streaming error-metric accumulator for approximate-multiplier
// evaluation. Each accepted (exact, approx) pair contributes to a sample count,
// an erroneous-sample count, a sum of error distances and a maximum error distance.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready. in_ready
// is decoded from the registered FSM state only (high in RUN), so there is no
// combinational path from in_valid; in_valid while in_ready is low is ignored.
module mult_err_analyzer #(
    parameter int W     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     exact,
    input  logic [W-1:0]     approx,
    input  logic             last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] ed_sum,
    output logic [W-1:0]     ed_max,
    output logic             overflow,
    output logic [1:0]       state_dbg
);
    // Sum is formed one bit wider than the larger of ed and the accumulator so
    // a carry out is visible for saturation even when ACC_W < W.
    localparam int SW = ((ACC_W > W) ? ACC_W : W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             done_q;
    logic             accept;
    logic [W:0]       diff;
    logic [W-1:0]     ed_d;

    logic             v1_q;
    logic [W-1:0]     ed1_q;
    logic             nz1_q;

    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
    logic [W-1:0]     ed_max_q, ed_max_d;
    logic             overflow_q, overflow_d;
    logic [SW-1:0]    sum_wide;

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state_q;

    // |exact - approx| via a W+1-bit difference; the magnitude always fits W bits.
    assign diff = {1'b0, exact} - {1'b0, approx};
    assign ed_d = diff[W] ? (~diff[W-1:0] + W'(1)) : diff[W-1:0];

    // Run-control FSM: the DRAIN cycle lets the last beat leave stage 2, so done
    // rises in the same cycle the final totals become visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE:    if (start) state_q <= RUN;
                RUN:     if (accept && last) state_q <= DRAIN;
                DRAIN: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage 1: capture error distance and nonzero flag of the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            ed1_q <= '0;
            nz1_q <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                ed1_q <= ed_d;
                nz1_q <= (ed_d != '0);
            end
        end
    end

    // Stage 2 next-state: clear on start, otherwise saturating accumulate.
    always_comb begin
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        ed_sum_d       = ed_sum_q;
        ed_max_d       = ed_max_q;
        overflow_d     = overflow_q;
        sum_wide       = SW'(ed_sum_q) + SW'(ed1_q);
        if ((state_q == IDLE) && start) begin
            sample_count_d = '0;
            err_count_d    = '0;
            ed_sum_d       = '0;
            ed_max_d       = '0;
            overflow_d     = 1'b0;
        end else if (v1_q) begin
            if (sample_count_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                sample_count_d = sample_count_q + CNT_W'(1);
            end
            if (nz1_q) begin
                if (err_count_q == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end
            if (sum_wide > SW'(ACC_MAX)) begin
                ed_sum_d   = ACC_MAX;
                overflow_d = 1'b1;
            end else begin
                ed_sum_d = sum_wide[ACC_W-1:0];
            end
            if (ed1_q > ed_max_q) begin
                ed_max_d = ed1_q;
            end
        end
    end

    // Stage 2 registers: results hold between runs until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            ed_sum_q       <= '0;
            ed_max_q       <= '0;
            overflow_q     <= 1'b0;
        end else begin
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            ed_sum_q       <= ed_sum_d;
            ed_max_q       <= ed_max_d;
            overflow_q     <= overflow_d;
        end
    end

    assign done         = done_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign ed_sum       = ed_sum_q;
    assign ed_max       = ed_max_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_mult_err_analyzer.sv
// Bench for mult_err_analyzer: a full-size instance plus a narrow-counter
// instance for saturation. Expected run totals are queued when a run is issued;
// per-instance monitors pop and compare whenever done pulses.
module tb_mult_err_analyzer;
    localparam int W       = 16;
    localparam int CNT_W   = 32;
    localparam int ACC_W   = 48;
    localparam int S_CNT_W = 4;
    localparam int S_ACC_W = 8;
    localparam int RW      = 2 * CNT_W + ACC_W + W + 1;
    localparam int SRW     = 2 * S_CNT_W + S_ACC_W + W + 1;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] err;
        logic [ACC_W-1:0] sum;
        logic [W-1:0]     mx;
        logic             ovf;
    } res_t;

    typedef struct packed {
        logic [S_CNT_W-1:0] cnt;
        logic [S_CNT_W-1:0] err;
        logic [S_ACC_W-1:0] sum;
        logic [W-1:0]       mx;
        logic               ovf;
    } sres_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           start_m = 1'b0;
    logic           start_s = 1'b0;
    logic           in_valid_m = 1'b0;
    logic           in_valid_s = 1'b0;
    logic [W-1:0]   exact_i = '0;
    logic [W-1:0]   approx_i = '0;
    logic           last_i = 1'b0;

    logic               rdy_m, busy_m, done_m, ovf_m;
    logic [CNT_W-1:0]   cnt_m, err_m;
    logic [ACC_W-1:0]   sum_m;
    logic [W-1:0]       max_m;
    logic [1:0]         st_m;

    logic               rdy_s, busy_s, done_s, ovf_s;
    logic [S_CNT_W-1:0] cnt_s, err_s;
    logic [S_ACC_W-1:0] sum_s;
    logic [W-1:0]       max_s;
    logic [1:0]         st_s;

    mult_err_analyzer #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start_m), .in_valid(in_valid_m),
        .in_ready(rdy_m), .exact(exact_i), .approx(approx_i), .last(last_i),
        .busy(busy_m), .done(done_m), .sample_count(cnt_m), .err_count(err_m),
        .ed_sum(sum_m), .ed_max(max_m), .overflow(ovf_m), .state_dbg(st_m)
    );

    mult_err_analyzer #(.W(W), .CNT_W(S_CNT_W), .ACC_W(S_ACC_W)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s),
        .in_ready(rdy_s), .exact(exact_i), .approx(approx_i), .last(last_i),
        .busy(busy_s), .done(done_s), .sample_count(cnt_s), .err_count(err_s),
        .ed_sum(sum_s), .ed_max(max_s), .overflow(ovf_s), .state_dbg(st_s)
    );

    // ---------------- scoreboard ----------------
    logic [RW-1:0]  exp_q[$];
    logic [SRW-1:0] exp_s_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        res_t r;
        if (!rst && done_m === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL main_unexpected_done: got done=1, required no done (no run pending)");
            end else begin
                r = exp_q.pop_front();
                check("main_sample_count", 64'(cnt_m), 64'(r.cnt));
                check("main_err_count",    64'(err_m), 64'(r.err));
                check("main_ed_sum",       64'(sum_m), 64'(r.sum));
                check("main_ed_max",       64'(max_m), 64'(r.mx));
                check("main_overflow",     64'(ovf_m), 64'(r.ovf));
            end
        end
    end

    always @(negedge clk) begin
        sres_t r;
        if (!rst && done_s === 1'b1) begin
            if (exp_s_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sat_unexpected_done: got done=1, required no done (no run pending)");
            end else begin
                r = exp_s_q.pop_front();
                check("sat_sample_count", 64'(cnt_s), 64'(r.cnt));
                check("sat_err_count",    64'(err_s), 64'(r.err));
                check("sat_ed_sum",       64'(sum_s), 64'(r.sum));
                check("sat_ed_max",       64'(max_s), 64'(r.mx));
                check("sat_overflow",     64'(ovf_s), 64'(r.ovf));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input bit sat);
        @(negedge clk);
        if (sat) start_s = 1'b1; else start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic send_beat(input bit sat, input logic [W-1:0] e, input logic [W-1:0] a, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        exact_i  = e;
        approx_i = a;
        last_i   = l;
        if (sat) in_valid_s = 1'b1; else in_valid_m = 1'b1;
        while (((sat ? rdy_s : rdy_m) !== 1'b1) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: in_ready=0 for 50 cycles, required 1");
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid_m = 1'b0;
        in_valid_s = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic wait_done(input bit sat);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((sat ? done_s : done_m) !== 1'b1) && guard < 100);
        if ((sat ? done_s : done_m) !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done=0 after 100 cycles, required 1");
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0]     p, ap, ged;
        logic [CNT_W-1:0] g_cnt, g_err;
        logic [ACC_W-1:0] g_sum;
        logic [W-1:0]     g_max;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_sample_count", 64'(cnt_m), 64'd0);
        check("rst_err_count",    64'(err_m), 64'd0);
        check("rst_ed_sum",       64'(sum_m), 64'd0);
        check("rst_ed_max",       64'(max_m), 64'd0);
        check("rst_overflow",     64'(ovf_m), 64'd0);
        check("rst_in_ready",     64'(rdy_m), 64'd0);
        check("rst_busy",         64'(busy_m), 64'd0);
        check("rst_done",         64'(done_m), 64'd0);
        check("rst_sat_in_ready", 64'(rdy_s), 64'd0);

        // Basic 4-beat run: ed = 0, 0x10, 0x10, 0xFFFF.
        exp_q.push_back({32'd4, 32'd3, 48'd65567, 16'hFFFF, 1'b0});
        start_run(1'b0);
        check("run_busy",     64'(busy_m), 64'd1);
        check("run_in_ready", 64'(rdy_m), 64'd1);
        send_beat(1'b0, 16'h00C8, 16'h00C8, 1'b0);
        send_beat(1'b0, 16'h1000, 16'h0FF0, 1'b0);
        send_beat(1'b0, 16'h0010, 16'h0020, 1'b0);
        send_beat(1'b0, 16'hFFFF, 16'h0000, 1'b1);
        @(negedge clk);
        check("drain_in_ready", 64'(rdy_m), 64'd0);
        check("drain_busy",     64'(busy_m), 64'd1);
        check("drain_done",     64'(done_m), 64'd0);
        @(negedge clk);
        check("done_latency",   64'(done_m), 64'd1);
        check("done_busy",      64'(busy_m), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done_m), 64'd0);

        // in_valid in IDLE is ignored; results hold.
        exact_i    = 16'h0000;
        approx_i   = 16'hFFFF;
        in_valid_m = 1'b1;
        repeat (4) @(negedge clk);
        in_valid_m = 1'b0;
        check("idle_in_ready",     64'(rdy_m), 64'd0);
        check("idle_sample_count", 64'(cnt_m), 64'd4);
        check("idle_ed_sum",       64'(sum_m), 64'd65567);

        // Gaps of two cycles between three beats of ed=5.
        exp_q.push_back({32'd3, 32'd3, 48'd15, 16'd5, 1'b0});
        start_run(1'b0);
        check("start_clears_count", 64'(cnt_m), 64'd0);
        send_beat(1'b0, 16'h0105, 16'h0100, 1'b0);
        repeat (2) @(negedge clk);
        send_beat(1'b0, 16'h0200, 16'h0205, 1'b0);
        repeat (2) @(negedge clk);
        send_beat(1'b0, 16'h0009, 16'h0004, 1'b1);
        wait_done(1'b0);

        // Single-beat run at the maximum distance.
        exp_q.push_back({32'd1, 32'd1, 48'd65535, 16'hFFFF, 1'b0});
        start_run(1'b0);
        send_beat(1'b0, 16'h0000, 16'hFFFF, 1'b1);
        wait_done(1'b0);

        // Identical inputs: no errors, zero distance.
        exp_q.push_back({32'd2, 32'd0, 48'd0, 16'd0, 1'b0});
        start_run(1'b0);
        send_beat(1'b0, 16'h1234, 16'h1234, 1'b0);
        send_beat(1'b0, 16'hABCD, 16'hABCD, 1'b1);
        wait_done(1'b0);

        // Saturation: 17 beats of ed=20 into 4-bit counters and an 8-bit sum.
        exp_s_q.push_back({4'd15, 4'd15, 8'd255, 16'd20, 1'b1});
        start_run(1'b1);
        for (int i = 0; i < 17; i++) begin
            send_beat(1'b1, 16'd30, 16'd10, (i == 16));
        end
        wait_done(1'b1);
        start_run(1'b1);
        check("sat_restart_overflow", 64'(ovf_s), 64'd0);
        check("sat_restart_count",    64'(cnt_s), 64'd0);
        check("sat_restart_sum",      64'(sum_s), 64'd0);
        exp_s_q.push_back({4'd1, 4'd1, 8'd20, 16'd20, 1'b0});
        send_beat(1'b1, 16'd10, 16'd30, 1'b1);
        wait_done(1'b1);

        // Reset after five accepted beats: partial results discarded, no done.
        start_run(1'b0);
        for (int i = 0; i < 5; i++) begin
            send_beat(1'b0, 16'h0010, 16'h0003, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state",    64'(st_m), 64'd0);
        check("midrst_in_ready", 64'(rdy_m), 64'd0);
        check("midrst_busy",     64'(busy_m), 64'd0);
        check("midrst_count",    64'(cnt_m), 64'd0);
        check("midrst_err",      64'(err_m), 64'd0);
        check("midrst_sum",      64'(sum_m), 64'd0);
        check("midrst_max",      64'(max_m), 64'd0);
        repeat (6) @(negedge clk);
        check("midrst_no_done",  64'(done_m), 64'd0);

        // Exhaustive 8x8 sweep: exact product against a top-8-bit truncation.
        g_cnt = '0;
        g_err = '0;
        g_sum = '0;
        g_max = '0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                p   = 16'(a * b);
                ap  = p & 16'hFF00;
                ged = (p > ap) ? (p - ap) : (ap - p);
                g_cnt = g_cnt + 1;
                if (p != ap) g_err = g_err + 1;
                g_sum = g_sum + ACC_W'(ged);
                if (ged > g_max) g_max = ged;
            end
        end
        exp_q.push_back({g_cnt, g_err, g_sum, g_max, 1'b0});
        start_run(1'b0);
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                p = 16'(a * b);
                send_beat(1'b0, p, p & 16'hFF00, (a == 255) && (b == 255));
            end
        end
        wait_done(1'b0);
        repeat (5) @(negedge clk);
        check("main_queue_drained", 64'(exp_q.size()), 64'd0);
        check("sat_queue_drained",  64'(exp_s_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
